// File: rtl/mem_arbiter_pkg.sv
// Shared types and width constants for the unified memory bus arbiter.
// Both requesters and the RAM share these widths.
package mem_arbiter_pkg;

    localparam int unsigned InstAddrW = 32;
    localparam int unsigned RegW      = 32;
    localparam int unsigned SelW      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StBusyIf,
        StBusyDm,
        StRespIf,
        StRespDm
    } mem_arb_state_t;

    typedef struct packed {
        logic                 req;
        logic                 we;
        logic [SelW-1:0]      sel;
        logic [InstAddrW-1:0] addr;
        logic [RegW-1:0]      wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used for the fetch starvation count and the access timeout count.
module sat_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Limit = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != Width'(Limit))) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data requesters onto one single-port RAM bus.
// Data has priority; fetch wins outright after STARVE_LIMIT lost arbitrations.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = InstAddrW,
    parameter int unsigned DATA_W       = RegW,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_sel,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              bus_err,
    output logic              stall_req
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned ToW     = $clog2(TIMEOUT + 1);

    mem_arb_state_t     state;
    mem_req_t           grant;
    logic [StarveW-1:0] starve_cnt;
    logic [ToW-1:0]     to_cnt;
    logic               idle, busy, starved, grant_if, grant_dm, timed_out;

    assign idle      = (state == StIdle);
    assign busy      = (state == StBusyIf) || (state == StBusyDm);
    assign starved   = (starve_cnt >= StarveW'(STARVE_LIMIT));
    assign grant_if  = if_req && (!dm_req || starved);
    assign grant_dm  = dm_req && !grant_if;
    assign timed_out = (to_cnt == ToW'(TIMEOUT - 1));
    assign stall_req = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    always_comb begin
        grant = '0;
        if (grant_if) begin
            grant.req  = 1'b1;
            grant.we   = 1'b0;
            grant.sel  = '1;
            grant.addr = if_addr;
        end else if (grant_dm) begin
            grant.req   = 1'b1;
            grant.we    = dm_we;
            grant.sel   = dm_sel;
            grant.addr  = dm_addr;
            grant.wdata = dm_wdata;
        end
    end

    sat_counter #(
        .Width(StarveW),
        .Limit(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (idle && if_req && grant_dm),
        .clr  (idle && grant_if),
        .count(starve_cnt)
    );

    // Held at zero outside BUSY so every access starts with a full budget.
    sat_counter #(
        .Width(ToW),
        .Limit(TIMEOUT - 1)
    ) u_to_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (busy && !ram_ack),
        .clr  (!busy || ram_ack),
        .count(to_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant.req) begin
                        ram_ce    <= 1'b1;
                        ram_we    <= grant.we;
                        ram_sel   <= grant.sel;
                        ram_addr  <= grant.addr;
                        ram_wdata <= grant.wdata;
                        state     <= grant_if ? StBusyIf : StBusyDm;
                    end
                end
                StBusyIf, StBusyDm: begin
                    if (ram_ack || timed_out) begin
                        ram_ce  <= 1'b0;
                        bus_err <= !ram_ack;
                        if (state == StBusyIf) begin
                            if_ready <= 1'b1;
                            if_rdata <= ram_ack ? ram_rdata : '0;
                            state    <= StRespIf;
                        end else begin
                            dm_ready <= 1'b1;
                            dm_rdata <= ram_ack ? ram_rdata : '0;
                            state    <= StRespDm;
                        end
                    end
                end
                StRespIf, StRespDm: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    if_rdata <= '0;
                    dm_rdata <= '0;
                    bus_err  <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: directed scenarios then random traffic,
// checked against a requester/arbitration model driven by the bench.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, dm_req, dm_we, dm_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_sel, ram_sel;
    logic        ram_ce, ram_we, ram_ack, bus_err, stall_req;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_sel   (dm_sel),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_sel  (ram_sel),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ack  (ram_ack),
        .bus_err  (bus_err),
        .stall_req(stall_req)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side model state: pending flags and held payloads.
    bit          if_pend, dm_pend;
    logic [31:0] if_a, dm_a, dm_wd;
    logic        dm_w;
    logic [3:0]  dm_s;
    int          starve_m;
    bit          got_if;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        if_req   = if_pend;
        if_addr  = if_a;
        dm_req   = dm_pend;
        dm_we    = dm_w;
        dm_sel   = dm_s;
        dm_addr  = dm_a;
        dm_wdata = dm_wd;
    endtask

    task automatic new_dm(input logic we, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] wd);
        dm_pend = 1'b1;
        dm_w    = we;
        dm_s    = sel;
        dm_a    = a;
        dm_wd   = wd;
    endtask

    // Entered in an IDLE cycle (posedge+1); returns in the following IDLE cycle.
    task automatic run_txn(input int delay, input logic [31:0] rd);
        bit          win_if, win_dm, to;
        int          last;
        logic [31:0] exp_rd;
        drive_reqs();
        ram_ack   = 1'($urandom_range(0, 1));
        ram_rdata = $urandom;
        #1;
        check_eq("idle_ce", ram_ce, 0);
        check_eq("idle_out", {if_ready, dm_ready, bus_err, if_rdata, dm_rdata}, 0);
        check_eq("idle_stall", stall_req, if_pend | dm_pend);
        win_if = if_pend && (!dm_pend || starve_m >= STARVE_LIMIT);
        win_dm = dm_pend && !win_if;
        got_if = 1'b0;
        if (!win_if && !win_dm) begin
            step();
            ram_ack = 1'b0;
            return;
        end
        if (win_if) starve_m = 0;
        else if (if_pend) starve_m++;
        to     = (delay >= TIMEOUT);
        last   = to ? TIMEOUT - 1 : delay;
        exp_rd = '0;
        for (int k = 0; k <= last; k++) begin
            step();
            ram_ack   = (k == delay);
            ram_rdata = rd;
            if (k == delay) exp_rd = rd;
            #1;
            check_eq("busy_ce", ram_ce, 1);
            check_eq("busy_rdy", {if_ready, dm_ready, bus_err}, 0);
            check_eq("busy_stall", stall_req, 1);
            if (win_if)
                check_eq("busy_if_bus", {ram_we, ram_sel, ram_addr}, {1'b0, 4'hF, if_a});
            else
                check_eq("busy_dm_bus", {ram_we, ram_sel, ram_addr, ram_wdata},
                         {dm_w, dm_s, dm_a, dm_wd});
        end
        step();
        ram_ack   = 1'($urandom_range(0, 1));
        ram_rdata = $urandom;
        #1;
        got_if = if_ready;
        check_eq("resp_ce", ram_ce, 0);
        check_eq("resp_rdy", {if_ready, dm_ready}, {win_if, win_dm});
        check_eq("resp_err", bus_err, to);
        check_eq("resp_if_rdata", if_rdata, win_if ? exp_rd : 32'h0);
        check_eq("resp_dm_rdata", dm_rdata, win_dm ? exp_rd : 32'h0);
        check_eq("resp_stall", stall_req, win_if ? dm_pend : if_pend);
        if (win_if) if_pend = 1'b0;
        else dm_pend = 1'b0;
        step();
        ram_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dm_wins;
        int dly;
        rst      = 1'b1;
        if_pend  = 0;
        dm_pend  = 0;
        if_a     = '0;
        dm_a     = '0;
        dm_wd    = '0;
        dm_w     = 0;
        dm_s     = '0;
        starve_m = 0;
        ram_ack  = 0;
        ram_rdata = '0;
        drive_reqs();
        step();
        step();
        check_eq("rst_out_a", {if_ready, dm_ready, bus_err, if_rdata, dm_rdata}, 0);
        check_eq("rst_out_b", {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata}, 0);
        rst = 1'b0;
        step();

        // Single fetch with immediate ack.
        if_pend = 1;
        if_a    = 32'h0000_0010;
        run_txn(0, 32'h3C01_0001);

        // Simultaneous: data first, then fetch.
        if_pend = 1;
        if_a    = 32'h0000_0014;
        new_dm(1'b0, 4'hF, 32'h0000_0080, 32'h0);
        run_txn(0, 32'h1111_2222);
        check_eq("simul_first_dm", got_if, 0);
        run_txn(1, 32'h3333_4444);
        check_eq("simul_then_if", got_if, 1);

        // Starvation: data re-requests back-to-back while fetch waits.
        if_pend = 1;
        if_a    = 32'h0000_0100;
        dm_wins = 0;
        for (int i = 0; i < 5; i++) begin
            if (!dm_pend) new_dm(1'b0, 4'hF, 32'h200 + 32'(i * 4), 32'h0);
            run_txn(i % 3, $urandom);
            if (!got_if) dm_wins++;
        end
        check_eq("starve_dm_wins", dm_wins, STARVE_LIMIT);
        check_eq("starve_if_won", got_if, 1);
        dm_pend = 0;
        run_txn(0, 32'h0);

        // Data write with a delayed ack.
        new_dm(1'b1, 4'b0011, 32'h0000_0300, 32'hDEAD_BEEF);
        run_txn(3, 32'h5555_6666);

        // Timeout then a normal access.
        new_dm(1'b0, 4'hF, 32'h0000_0400, 32'h0);
        run_txn(100, 32'hAAAA_BBBB);
        if_pend = 1;
        if_a    = 32'h0000_0020;
        run_txn(0, 32'h2402_0005);

        // Reset during a data access.
        new_dm(1'b0, 4'hF, 32'h0000_0500, 32'h0);
        drive_reqs();
        step();
        step();
        step();
        check_eq("pre_rst_ce", ram_ce, 1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_a", {if_ready, dm_ready, bus_err, if_rdata, dm_rdata}, 0);
        check_eq("mid_rst_b", {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata}, 0);
        rst      = 1'b0;
        dm_pend  = 0;
        starve_m = 0;
        drive_reqs();
        step();
        check_eq("post_rst_quiet", {ram_ce, dm_ready, if_ready}, 0);
        new_dm(1'b1, 4'b1100, 32'h0000_0600, 32'h1234_5678);
        run_txn(1, 32'h9);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1;
                if_a    = {$urandom_range(0, 255), 2'b00};
            end
            if (!dm_pend && $urandom_range(0, 2) != 0)
                new_dm(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       32'h1000 + {$urandom_range(0, 255), 2'b00}, $urandom);
            case ($urandom_range(0, 15))
                0:       dly = 40;
                1:       dly = TIMEOUT - 1;
                default: dly = $urandom_range(0, 3);
            endcase
            run_txn(dly, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory bus between the instruction-fetch requester (pc stage) and the data requester (mem stage).
- Grants one access at a time. Data has priority, with starvation protection for fetch.
- Bounds each memory access with a timeout.
- Drives stall_req to the pipeline control logic while any request is outstanding.
- Sits between the openmips core boundary and the external RAM.

Parameters:
ADDR_W, 32, address width of both requesters and the RAM
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive cycles fetch may lose arbitration before it wins outright
TIMEOUT, 16, max cycles in a busy state without ram_ack before the access is aborted

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, held until dm_ready
dm_we  in  1  1 = write, 0 = read
dm_sel  in  4  byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  data read data, valid while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data
ram_ce  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_sel  out  4  RAM byte enables
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completion, sampled only while ram_ce=1
bus_err  out  1  one-cycle pulse alongside ready when the access timed out
stall_req  out  1  pipeline stall request

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
- Reset: state=IDLE; all outputs 0; starve_cnt=0; to_cnt=0.
  - Reset mid-access aborts the access. ram_ce is 0 after that edge, and no ready pulse is issued.
- IDLE arbitration:
  - dm_req wins.
  - Exception: if_req wins when starve_cnt >= STARVE_LIMIT.
  - Only one requester present: that requester wins.
  - Neither present: stay in IDLE.
- Grant edge:
  - Latch address, we, sel and wdata into registers driving ram_*.
  - For a fetch grant: ram_we=0, ram_sel=4'hF.
  - Move to BUSY_x.
- BUSY_x:
  - ram_ce=1; ram_* are stable for the whole state.
  - ram_ack=1: capture ram_rdata (captured for writes too), clear to_cnt, go to RESP_x.
  - No ack: to_cnt++. When to_cnt reaches TIMEOUT-1 without ack, go to RESP_x with rdata=0 and the error flag set.
- RESP_x:
  - ram_ce=0.
  - x_ready=1 for exactly this cycle; x_rdata holds the captured value; bus_err reflects the error flag.
  - Next state is IDLE.
  - Outside RESP, ready, bus_err and rdata are driven to 0.
- Latency: request seen in IDLE at cycle N; ram_ce asserted N+1. With ram_ack at N+1, ready is at N+2. Minimum 3 cycles per access, including the IDLE re-arbitration cycle.
- Requester protocol:
  - Hold req and its payload constant until ready.
  - Drop req in the cycle after ready unless a new access is intended. req still high in the following IDLE is treated as a new request.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each IDLE arbitration edge where if_req=1 and dm wins.
  - Clears to 0 when fetch is granted.
  - Unchanged otherwise.
- stall_req is combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).
- ram_ack outside a BUSY state is ignored.
- Simultaneous requests: see arbitration. The loser keeps waiting with its req held.

Decomposition:
- project_types package gets: mem_arb_state_t enum (IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM) and the mem_req_t struct {req, we, sel, addr, wdata}.
- Port widths come from the existing inst/reg width constants.
- One natural sub-module: sat_counter (parameterised width/limit, with inc and clr inputs). It is instantiated twice, for starve_cnt and to_cnt.
- FSM and datapath registers live in mem_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000010, ram_ack at the first ram_ce cycle with ram_rdata=0x3C010001 -> ram_ce at N+1 with ram_addr=0x10, ram_we=0; if_ready=1 with if_rdata=0x3C010001 at N+2; stall_req=1 for N..N+1.
- Simultaneous requests: if_req and dm_req both raised at cycle N, dm read of 0x80 -> data served first, fetch after; starve_cnt=1 during the data access.
- Starvation: dm_req held continuously (back-to-back), if_req held -> after 4 data wins, the 5th arbitration grants fetch; starve_cnt returns to 0.
- Data write: dm_we=1, dm_sel=4'b0011, dm_wdata=0xDEADBEEF, ram_ack delayed 3 cycles -> ram_* stable for all 4 BUSY cycles; dm_ready after ack; bus_err=0.
- Timeout: ram_ack never asserted -> exactly TIMEOUT=16 BUSY cycles, then ready=1, rdata=0, bus_err=1 for one cycle; the next request proceeds normally.
- Reset mid-access: rst=1 during BUSY_DM -> ram_ce=0 after the reset edge; no dm_ready; all outputs 0; a new request after reset is granted normally.
